tx_block_sequencer: RTL and testbench
=====================================

Name: tx_block_sequencer

Overview:
Sequences one 128-bit ciphertext block through the byte-serialising transmit FIFO and out to the UART transmitter. On a start pulse it loads the FIFO and pops the 16 bytes in address order (byte 0 = bits [7:0] first). Each byte is handed to the UART over a valid/ready handshake, optionally followed by a CR/LF trailer. It sits between the encryption core's done strobe and the FIFO/UART pair, replacing the manual write/read buttons.

Parameters:
DATA_SIZE, 8, bits per transmitted byte
BYTES_PER_BLOCK, 16, bytes popped from the FIFO per block
APPEND_CRLF, 1, 1 = send 8'h0D then 8'h0A after the block; 0 = no trailer

Ports:
clk_100MHz  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to transmit the block currently on the FIFO data input
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_SIZE  FIFO read data (combinational from current read address)
fifo_write  output  1  one-cycle load strobe to the FIFO
fifo_read  output  1  one-cycle pop strobe to the FIFO
tx_data  output  DATA_SIZE  byte presented to the UART
tx_valid  output  1  tx_data is valid; held until accepted
tx_ready  input  1  UART can accept a byte; transfer occurs when tx_valid && tx_ready
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the block (and trailer) has been accepted
error  output  1  sticky; set on FIFO underrun; cleared only by reset or the next accepted start

Behaviour:
- Reset (async, reset_n low): state IDLE, byte_cnt 0, trl_cnt 0, tx_data 0. All outputs 0. Reset mid-block abandons it immediately; no further strobes are issued.
- Only one of fifo_write / fifo_read is ever high in a cycle. Neither is high outside LOAD and SEND.
- States:
  - IDLE: if start, go to LOAD and clear error. Otherwise stay.
  - LOAD: assert fifo_write for exactly one cycle, clear byte_cnt, go to WAIT_LOAD.
  - WAIT_LOAD: one cycle, lets the FIFO flags and read address settle, go to FETCH.
  - FETCH:
    - If fifo_empty: set error and go to DONE (underrun).
    - Else: register tx_data <= fifo_data and go to SEND.
  - SEND:
    - tx_valid is high and tx_data is stable.
    - On tx_valid && tx_ready: pulse fifo_read the same cycle and increment byte_cnt.
    - Then, if byte_cnt == BYTES_PER_BLOCK-1 (last byte), go to TRAILER if APPEND_CRLF, else DONE.
    - Otherwise go back to FETCH.
    - If !tx_ready: hold state with no strobes.
  - TRAILER:
    - tx_valid is high; tx_data = 8'h0D when trl_cnt = 0, 8'h0A when trl_cnt = 1.
    - On handshake, increment trl_cnt. After the second acceptance, clear trl_cnt and go to DONE.
    - The FIFO is not touched.
  - DONE: done = 1 for one cycle, go to IDLE.
- start is ignored while busy. A start in the DONE cycle is also ignored. A start in the first IDLE cycle after DONE is accepted.
- tx_valid never drops before acceptance. tx_data never changes while tx_valid && !tx_ready.
- Per-byte cost is 2 cycles minimum (FETCH + SEND) with tx_ready tied high.
- Latency from start to first tx_valid is 4 cycles: start seen in IDLE → LOAD → WAIT_LOAD → FETCH → SEND.
- byte_cnt is $clog2(BYTES_PER_BLOCK)+1 bits wide and never wraps within a block.
- An underrun does not drive tx_valid, and error stays high through DONE and IDLE.

Test Plan:
- Block = 128'h0F0E..0100, tx_ready tied 1, APPEND_CRLF=1, pulse start. Expect:
  - fifo_write exactly once, 1 cycle after start.
  - First tx_valid 4 cycles after start.
  - tx bytes 00,01,...,0F,0D,0A in order, 16 fifo_read pulses.
  - done 1 cycle after the 0A handshake; total 37 cycles start→done.
- Same block, tx_ready high only 1 cycle in every 5. Expect:
  - tx_data/tx_valid stable while stalled.
  - fifo_read only on handshake cycles.
  - Identical byte sequence.
- Pulse start repeatedly while busy. Expect no extra fifo_write and the byte stream unaffected. A start 1 cycle after done begins a new block.
- Force fifo_empty=1 in FETCH after 5 bytes. Expect error=1, done pulse, no 6th tx_valid, IDLE. The next start clears error.
- Assert reset_n low during SEND of byte 7. Expect immediately: tx_valid=0, busy=0, no strobes. After release, IDLE; a new start transmits from byte 00.
- APPEND_CRLF=0. Expect exactly 16 handshakes, no 0D/0A, done 1 cycle after byte 0F accepted.

Source files
------------

// File: rtl/tx_block_sequencer.sv
// ============================================================================
//  Module   : tx_block_sequencer
//  Brief    : Pops one ciphertext block from the transmit FIFO and hands each
//             byte (plus optional CR/LF trailer) to the UART over valid/ready.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tx_block_sequencer #(
    parameter int DATA_SIZE       = 8,
    parameter int BYTES_PER_BLOCK = 16,
    parameter int APPEND_CRLF     = 1
) (
    input  logic                 clk_100MHz,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_write,
    output logic                 fifo_read,
    output logic [DATA_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int                   c_CNT_W = $clog2(BYTES_PER_BLOCK) + 1;
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(BYTES_PER_BLOCK - 1);
    localparam logic [DATA_SIZE-1:0] c_CR    = DATA_SIZE'(8'h0D);
    localparam logic [DATA_SIZE-1:0] c_LF    = DATA_SIZE'(8'h0A);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_LOAD = 3'd2,
        ST_FETCH     = 3'd3,
        ST_SEND      = 3'd4,
        ST_TRAILER   = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_byte_cnt;
    logic                 r_trl_cnt;
    logic [DATA_SIZE-1:0] r_tx_data;
    logic                 r_error;
    logic                 w_last_byte;

    assign w_last_byte = (r_byte_cnt == c_LAST);

    always_comb begin
        w_state_next = r_state;
        fifo_write   = 1'b0;
        fifo_read    = 1'b0;
        tx_valid     = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_write   = 1'b1;
                w_state_next = ST_WAIT_LOAD;
            end
            ST_WAIT_LOAD: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_state_next = fifo_empty ? ST_DONE : ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                // The pop coincides with acceptance so the FIFO never runs ahead of the UART
                if (tx_ready) begin
                    fifo_read = 1'b1;
                    if (w_last_byte)
                        w_state_next = (APPEND_CRLF != 0) ? ST_TRAILER : ST_DONE;
                    else
                        w_state_next = ST_FETCH;
                end
            end
            ST_TRAILER: begin
                tx_valid = 1'b1;
                if (tx_ready && r_trl_cnt) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_trl_cnt  <= 1'b0;
            r_tx_data  <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) r_error <= 1'b0;
                end
                ST_LOAD: begin
                    r_byte_cnt <= '0;
                end
                ST_FETCH: begin
                    if (fifo_empty) r_error   <= 1'b1;
                    else            r_tx_data <= fifo_data;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
                        // Preload the CR so the trailer byte is registered like the data bytes
                        if (w_last_byte && (APPEND_CRLF != 0)) r_tx_data <= c_CR;
                    end
                end
                ST_TRAILER: begin
                    if (tx_ready) begin
                        r_trl_cnt <= ~r_trl_cnt;
                        r_tx_data <= c_LF;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data = r_tx_data;
    assign busy    = (r_state != ST_IDLE);
    assign error   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_tx_block_sequencer.sv
// ============================================================================
//  Module   : tb_tx_block_sequencer
//  Brief    : Drives two sequencers (with and without CR/LF trailer) against a
//             FIFO model and checks the byte stream, strobes and timing.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tx_block_sequencer;

    logic         clk_100MHz = 1'b0;
    logic         reset_n;
    logic [1:0]   start_v;
    logic         tx_ready;
    logic         force_empty;
    logic [1:0]   fifo_empty, fifo_write, fifo_read, tx_valid, busy, done, error;
    logic [7:0]   fifo_data [2];
    logic [7:0]   tx_data   [2];
    logic [127:0] blk;

    always #5 clk_100MHz = ~clk_100MHz;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tx_block_sequencer #(
            .DATA_SIZE       (8),
            .BYTES_PER_BLOCK (16),
            .APPEND_CRLF     (g)
        ) u_dut (
            .clk_100MHz (clk_100MHz),
            .reset_n    (reset_n),
            .start      (start_v[g]),
            .fifo_empty (fifo_empty[g]),
            .fifo_data  (fifo_data[g]),
            .fifo_write (fifo_write[g]),
            .fifo_read  (fifo_read[g]),
            .tx_data    (tx_data[g]),
            .tx_valid   (tx_valid[g]),
            .tx_ready   (tx_ready),
            .busy       (busy[g]),
            .done       (done[g]),
            .error      (error[g])
        );
    end

    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    // FIFO model: a load copies the whole block, each pop advances the read address
    logic [7:0] fmem [2][16];
    logic [3:0] frp  [2];
    logic [4:0] fcnt [2];

    always @(posedge clk_100MHz) begin
        for (int g = 0; g < 2; g++) begin
            if (!reset_n) begin
                frp[g]  <= 4'd0;
                fcnt[g] <= 5'd0;
            end else if (fifo_write[g]) begin
                for (int i = 0; i < 16; i++) fmem[g][i] <= blk[8*i +: 8];
                frp[g]  <= 4'd0;
                fcnt[g] <= 5'd16;
            end else if (fifo_read[g]) begin
                frp[g]  <= frp[g] + 4'd1;
                fcnt[g] <= fcnt[g] - 5'd1;
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            fifo_empty[g] = (fcnt[g] == 5'd0) || force_empty;
            fifo_data[g]  = fmem[g][frp[g]];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Observation state, written only by the stimulus process
    logic [7:0] got [2][$];
    int   n_wr [2], n_rd [2], n_done [2];
    int   wr_cyc [2], first_cyc [2], done_cyc [2];
    logic err_at_done [2];
    logic seek_first [2];
    logic [1:0] prev_vld;
    logic [7:0] prev_data [2];
    logic prev_rdy;
    int   ready_mode, rphase;
    int   b_got [2], b_wr [2], b_rd [2], b_done [2];

    function automatic logic [7:0] exp_byte(input logic [127:0] b, input int i);
        if (i < 16)       return b[8*i +: 8];
        else if (i == 16) return 8'h0D;
        else              return 8'h0A;
    endfunction

    // One clock: observe at the falling edge, then update inputs just after the rising edge
    task automatic tick();
        @(negedge clk_100MHz);
        if (reset_n) begin
            for (int g = 0; g < 2; g++) begin
                check("wr_rd_excl", 32'(fifo_write[g] & fifo_read[g]), 0);
                if (fifo_read[g]) check("read_on_handshake", 32'(tx_valid[g] & tx_ready), 1);
                if (prev_vld[g] && !prev_rdy) begin
                    check("stall_valid_held", 32'(tx_valid[g]), 1);
                    check("stall_data_held", 32'(tx_data[g]), 32'(prev_data[g]));
                end
                if (fifo_write[g]) begin
                    n_wr[g]++;
                    wr_cyc[g]     = cyc;
                    seek_first[g] = 1'b1;
                end
                if (fifo_read[g]) n_rd[g]++;
                if (tx_valid[g] && seek_first[g]) begin
                    first_cyc[g]  = cyc;
                    seek_first[g] = 1'b0;
                end
                if (tx_valid[g] && tx_ready) got[g].push_back(tx_data[g]);
                if (done[g]) begin
                    n_done[g]++;
                    done_cyc[g]    = cyc;
                    err_at_done[g] = error[g];
                end
                prev_vld[g]  = tx_valid[g];
                prev_data[g] = tx_data[g];
            end
        end else begin
            prev_vld = 2'b00;
        end
        prev_rdy = tx_ready;
        @(posedge clk_100MHz);
        #1;
        rphase++;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (rphase % 5 == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic snapshot();
        for (int g = 0; g < 2; g++) begin
            b_got[g]  = got[g].size();
            b_wr[g]   = n_wr[g];
            b_rd[g]   = n_rd[g];
            b_done[g] = n_done[g];
        end
    endtask

    task automatic wait_done(input int count);
        for (int t = 0; t < 3000; t++) begin
            if (n_done[0] - b_done[0] >= count && n_done[1] - b_done[1] >= count) break;
            tick();
        end
        for (int g = 0; g < 2; g++) check("done_count", n_done[g] - b_done[g], count);
    endtask

    task automatic check_stream(input int reps);
        for (int g = 0; g < 2; g++) begin
            int len = 16 + 2 * g;
            check("byte_count", got[g].size() - b_got[g], len * reps);
            if (got[g].size() - b_got[g] == len * reps)
                for (int i = 0; i < len * reps; i++)
                    check("byte_value", 32'(got[g][b_got[g] + i]), 32'(exp_byte(blk, i % len)));
            check("read_count", n_rd[g] - b_rd[g], 16 * reps);
            check("write_count", n_wr[g] - b_wr[g], reps);
        end
    endtask

    task automatic pulse_start(output int sc);
        start_v = 2'b11;
        sc      = cyc;
        tick();
        start_v = 2'b00;
        for (int g = 0; g < 2; g++) check("error_cleared_on_start", 32'(error[g]), 0);
    endtask

    task automatic run_block(input int mode, input logic [127:0] b, input bit spam);
        int sc;
        blk        = b;
        ready_mode = mode;
        snapshot();
        pulse_start(sc);
        for (int t = 0; t < 3000; t++) begin
            if (n_done[0] != b_done[0] && n_done[1] != b_done[1]) break;
            start_v = spam ? (busy & 2'($urandom)) : 2'b00;
            tick();
        end
        start_v = 2'b00;
        for (int g = 0; g < 2; g++) check("done_count", n_done[g] - b_done[g], 1);
        check_stream(1);
        if (mode == 0) begin
            for (int g = 0; g < 2; g++) begin
                check("write_latency", wr_cyc[g] - sc, 1);
                check("first_valid_latency", first_cyc[g] - sc, 4);
                check("done_latency", done_cyc[g] - sc, (g == 1) ? 37 : 35);
            end
        end
        tick();
        for (int g = 0; g < 2; g++) begin
            check("idle_busy", 32'(busy[g]), 0);
            check("idle_error", 32'(error[g]), 0);
        end
    endtask

    // A start in the DONE cycle is dropped; one in the following IDLE cycle is taken
    task automatic run_done_cycle_start();
        int sc;
        blk        = {$urandom(), $urandom(), $urandom(), $urandom()};
        ready_mode = 0;
        snapshot();
        pulse_start(sc);
        for (int t = 0; t < 40; t++) begin
            start_v[0] = (cyc - sc == 35) || (cyc - sc == 36);
            start_v[1] = (cyc - sc == 37) || (cyc - sc == 38);
            tick();
        end
        start_v = 2'b00;
        check("restart_write_cyc0", wr_cyc[0] - sc, 37);
        check("restart_write_cyc1", wr_cyc[1] - sc, 39);
        wait_done(2);
        check_stream(2);
        tick();
    endtask

    task automatic run_underrun();
        int sc;
        blk        = {$urandom(), $urandom(), $urandom(), $urandom()};
        ready_mode = 0;
        snapshot();
        pulse_start(sc);
        for (int t = 0; t < 200; t++) begin
            if (got[1].size() - b_got[1] >= 5) break;
            tick();
        end
        force_empty = 1'b1;
        wait_done(1);
        for (int i = 0; i < 4; i++) tick();
        for (int g = 0; g < 2; g++) begin
            check("underrun_bytes", got[g].size() - b_got[g], 5);
            check("underrun_reads", n_rd[g] - b_rd[g], 5);
            check("underrun_error_at_done", 32'(err_at_done[g]), 1);
            check("underrun_error_sticky", 32'(error[g]), 1);
            check("underrun_idle", 32'(busy[g]), 0);
            check("underrun_no_valid", 32'(tx_valid[g]), 0);
        end
        force_empty = 1'b0;
    endtask

    task automatic run_reset_mid_block();
        int sc;
        blk        = {$urandom(), $urandom(), $urandom(), $urandom()};
        ready_mode = 0;
        snapshot();
        pulse_start(sc);
        for (int t = 0; t < 200; t++) begin
            if (got[1].size() - b_got[1] >= 7) break;
            tick();
        end
        tick();
        for (int g = 0; g < 2; g++) begin
            check("pre_reset_valid", 32'(tx_valid[g]), 1);
            check("pre_reset_byte7", 32'(tx_data[g]), 32'(blk[63:56]));
        end
        reset_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check("reset_valid", 32'(tx_valid[g]), 0);
            check("reset_busy", 32'(busy[g]), 0);
            check("reset_read", 32'(fifo_read[g]), 0);
            check("reset_write", 32'(fifo_write[g]), 0);
            check("reset_done", 32'(done[g]), 0);
        end
        for (int i = 0; i < 3; i++) tick();
        for (int g = 0; g < 2; g++) check("reset_held_idle", 32'({busy[g], fifo_read[g], fifo_write[g]}), 0);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [127:0] ramp;
        for (int i = 0; i < 16; i++) ramp[8*i +: 8] = 8'(i);
        reset_n     = 1'b0;
        start_v     = 2'b00;
        tx_ready    = 1'b1;
        force_empty = 1'b0;
        ready_mode  = 0;
        rphase      = 0;
        blk         = '0;
        prev_vld    = 2'b00;
        prev_rdy    = 1'b0;
        for (int g = 0; g < 2; g++) begin
            n_wr[g] = 0; n_rd[g] = 0; n_done[g] = 0;
            wr_cyc[g] = 0; first_cyc[g] = 0; done_cyc[g] = 0;
            err_at_done[g] = 1'b0; seek_first[g] = 1'b0;
        end
        for (int i = 0; i < 3; i++) tick();
        for (int g = 0; g < 2; g++) begin
            check("rst_outputs", 32'({fifo_write[g], fifo_read[g], tx_valid[g], busy[g], done[g], error[g]}), 0);
            check("rst_tx_data", 32'(tx_data[g]), 0);
        end
        reset_n = 1'b1;
        tick();

        run_block(0, ramp, 1'b0);
        run_block(1, ramp, 1'b0);
        run_block(0, ramp, 1'b1);
        run_done_cycle_start();
        run_underrun();
        run_block(2, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        run_reset_mid_block();
        run_block(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        for (int k = 0; k < 3; k++)
            run_block(2, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
